// File: rtl/riscv_cache_mem_responder_pkg.sv
// Shared VC memory message definitions for the cache refill/writeback port.
// The cache side imports the same field positions and encodings.
package riscv_cache_mem_responder_pkg;

   localparam int unsigned c_req_msg_w     = 67;
   localparam int unsigned c_req_type_bit  = 66;
   localparam int unsigned c_req_addr_msb  = 65;
   localparam int unsigned c_req_addr_lsb  = 34;
   localparam int unsigned c_req_len_msb   = 33;
   localparam int unsigned c_req_len_lsb   = 32;
   localparam int unsigned c_req_data_msb  = 31;
   localparam int unsigned c_req_data_lsb  = 0;

   localparam int unsigned c_resp_msg_w    = 35;
   localparam int unsigned c_resp_type_bit = 34;
   localparam int unsigned c_resp_len_msb  = 33;
   localparam int unsigned c_resp_len_lsb  = 32;

   typedef enum logic {
      mem_type_rd = 1'b0,
      mem_type_wr = 1'b1
   } mem_type_e;

   typedef enum logic [1:0] {
      mem_len_word = 2'd0,
      mem_len_byte = 2'd1,
      mem_len_half = 2'd2,
      mem_len_bad  = 2'd3
   } mem_len_e;

   typedef enum logic [1:0] {
      st_idle = 2'd0,
      st_wait = 2'd1,
      st_resp = 2'd2
   } resp_state_e;

endpackage

// File: rtl/riscv_cache_mem_responder_subword.sv
// Byte-lane handling for sub-word accesses: write byte enables and merge,
// read extraction with zero extension. Purely combinational.
module riscv_mem_subword
   import riscv_cache_mem_responder_pkg::*;
(
   input  mem_len_e    len,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wr_data,
   input  logic [31:0] ram_word,
   output logic [3:0]  wr_be,
   output logic [31:0] wr_word,
   output logic [31:0] rd_data
);

   logic [31:0] wr_lanes_s;

   // lane selection from {len, addr_lo}; illegal len behaves as a word
   always_comb begin
      wr_be      = 4'b1111;
      wr_lanes_s = wr_data;
      rd_data    = ram_word;
      case (len)
         mem_len_byte: begin
            wr_be      = 4'b0001 << addr_lo;
            wr_lanes_s = {4{wr_data[7:0]}};
            rd_data    = (ram_word >> {addr_lo, 3'b000}) & 32'h0000_00FF;
         end
         mem_len_half: begin
            wr_be      = addr_lo[1] ? 4'b1100 : 4'b0011;
            wr_lanes_s = {2{wr_data[15:0]}};
            rd_data    = (ram_word >> {addr_lo[1], 4'b0000}) & 32'h0000_FFFF;
         end
         default: begin
            wr_be      = 4'b1111;
            wr_lanes_s = wr_data;
            rd_data    = ram_word;
         end
      endcase
   end

   // merge enabled lanes over the current RAM word
   always_comb begin
      wr_word = ram_word;
      for (int i = 0; i < 4; i++) begin
         wr_word[8*i +: 8] = wr_be[i] ? wr_lanes_s[8*i +: 8] : ram_word[8*i +: 8];
      end
   end

endmodule

// File: rtl/riscv_cache_mem_responder.sv
// Memory-side responder: accepts one cachereq at a time, performs the RAM access
// at accept, and presents the cacheresp a fixed number of cycles later.
module riscv_cache_mem_responder
   import riscv_cache_mem_responder_pkg::*;
#(
   parameter int unsigned p_mem_sz  = 65536,
   parameter int unsigned p_latency = 4
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cachereq_val,
   output logic                    cachereq_rdy,
   input  logic [c_req_msg_w-1:0]  cachereq_msg,
   output logic                    cacheresp_val,
   input  logic                    cacheresp_rdy,
   output logic [c_resp_msg_w-1:0] cacheresp_msg
);

   localparam int unsigned c_aw     = $clog2(p_mem_sz);
   localparam int unsigned c_iw     = (c_aw > 2) ? (c_aw - 2) : 1;
   localparam int unsigned c_words  = (p_mem_sz / 4 > 0) ? (p_mem_sz / 4) : 1;
   localparam logic [3:0]  c_lat_m1 = 4'(p_latency - 1);

   resp_state_e     state_r;
   resp_state_e     next_state_s;
   logic [3:0]      count_r;
   mem_type_e       resp_type_r;
   mem_len_e        resp_len_r;
   logic [31:0]     resp_data_r;
   logic [31:0]     mem_r [c_words];

   mem_type_e       req_type_s;
   mem_len_e        req_len_s;
   logic [31:0]     req_addr_s;
   logic [31:0]     req_data_s;
   logic [c_iw-1:0] idx_s;
   logic            accept_s;
   logic [3:0]      wr_be_s;
   logic [31:0]     wr_word_s;
   logic [31:0]     rd_data_s;
   logic            unused_addr_s;

   assign req_type_s = mem_type_e'(cachereq_msg[c_req_type_bit]);
   assign req_len_s  = mem_len_e'(cachereq_msg[c_req_len_msb:c_req_len_lsb]);
   assign req_addr_s = cachereq_msg[c_req_addr_msb:c_req_addr_lsb];
   assign req_data_s = cachereq_msg[c_req_data_msb:c_req_data_lsb];
   assign accept_s   = cachereq_val & cachereq_rdy;
   assign unused_addr_s = ^req_addr_s;

   // upper address bits are dropped so accesses wrap within the RAM
   generate
      if (c_aw > 2) begin : g_idx
         assign idx_s = req_addr_s[c_aw-1:2];
      end else begin : g_idx_single
         assign idx_s = 1'b0;
      end
   endgenerate

   riscv_mem_subword u_subword (
      .len      (req_len_s),
      .addr_lo  (req_addr_s[1:0]),
      .wr_data  (req_data_s),
      .ram_word (mem_r[idx_s]),
      .wr_be    (wr_be_s),
      .wr_word  (wr_word_s),
      .rd_data  (rd_data_s)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= st_idle;
      end else begin
         state_r <= next_state_s;
      end
   end

   // FSM next state; counter value 1 in WAIT is the last waiting cycle
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         st_idle: begin
            if (cachereq_val) begin
               next_state_s = (c_lat_m1 == 4'd0) ? st_resp : st_wait;
            end else begin
               next_state_s = st_idle;
            end
         end
         st_wait: begin
            if (count_r <= 4'd1) begin
               next_state_s = st_resp;
            end else begin
               next_state_s = st_wait;
            end
         end
         st_resp: begin
            if (cacheresp_rdy) begin
               next_state_s = st_idle;
            end else begin
               next_state_s = st_resp;
            end
         end
         default: next_state_s = st_idle;
      endcase
   end

   // FSM outputs
   always_comb begin
      cachereq_rdy  = (state_r == st_idle);
      cacheresp_val = (state_r == st_resp);
      cacheresp_msg = {resp_type_r, resp_len_r, resp_data_r};
   end

   // latency counter and response capture at accept
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r     <= 4'd0;
         resp_type_r <= mem_type_rd;
         resp_len_r  <= mem_len_word;
         resp_data_r <= 32'd0;
      end else if (accept_s) begin
         count_r     <= c_lat_m1;
         resp_type_r <= req_type_s;
         resp_len_r  <= req_len_s;
         resp_data_r <= (req_type_s == mem_type_wr) ? 32'd0 : rd_data_s;
      end else if (state_r == st_wait) begin
         count_r     <= count_r - 4'd1;
      end
   end

   // RAM write at accept; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (!reset && accept_s && (req_type_s == mem_type_wr) && (|wr_be_s)) begin
         mem_r[idx_s] <= wr_word_s;
      end
   end

endmodule

// File: tb/tb_riscv_cache_mem_responder.sv
// Self-checking bench for riscv_cache_mem_responder: directed scenarios plus
// randomized traffic against a byte-addressed memory model.
module tb_riscv_cache_mem_responder;
   import riscv_cache_mem_responder_pkg::*;

   localparam int unsigned L   = 4;
   localparam int unsigned MSZ = 65536;

   logic        clk = 1'b0;
   logic        reset;
   logic        cachereq_val;
   logic        cachereq_rdy;
   logic [66:0] cachereq_msg;
   logic        cacheresp_val;
   logic        cacheresp_rdy;
   logic [34:0] cacheresp_msg;

   int errors = 0;
   int checks = 0;
   logic [7:0] model_mem [MSZ];

   riscv_cache_mem_responder #(.p_mem_sz(MSZ), .p_latency(L)) dut (
      .clk           (clk),
      .reset         (reset),
      .cachereq_val  (cachereq_val),
      .cachereq_rdy  (cachereq_rdy),
      .cachereq_msg  (cachereq_msg),
      .cacheresp_val (cacheresp_val),
      .cacheresp_rdy (cacheresp_rdy),
      .cacheresp_msg (cacheresp_msg)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // byte-addressed reference: access size from len, aligned down, address wraps
   function automatic logic [34:0] model_txn(input bit t, input logic [31:0] a,
                                             input logic [1:0] l, input logic [31:0] d);
      int n;
      int base;
      logic [31:0] rd;
      n    = (l == 2'd1) ? 1 : (l == 2'd2) ? 2 : 4;
      base = int'(a % MSZ) & ~(n - 1);
      rd   = 32'd0;
      if (t) begin
         for (int i = 0; i < n; i++) model_mem[base + i] = d[8*i +: 8];
         return {1'b1, l, 32'd0};
      end
      for (int i = 0; i < n; i++) rd[8*i +: 8] = model_mem[base + i];
      return {1'b0, l, rd};
   endfunction

   // one full transaction, called and returning at a negedge
   task automatic txn(input string tag, input bit t, input logic [31:0] a,
                      input logic [1:0] l, input logic [31:0] d, input int hold,
                      output logic [34:0] got);
      logic [34:0] exp;
      int n;
      exp = model_txn(t, a, l, d);
      cachereq_msg = {t, a, l, d};
      cachereq_val = 1'b1;
      n = 0;
      while (!cachereq_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_accept"}, 35'(cachereq_rdy), 35'd1);
      @(negedge clk);
      cachereq_val = 1'b0;
      n = 1;
      while (!cacheresp_val && n < 40) begin
         check({tag, "_busy"}, 35'(cachereq_rdy), 35'd0);
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, 35'(n), 35'(L));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "_hold_val"}, 35'(cacheresp_val), 35'd1);
         check({tag, "_hold_msg"}, cacheresp_msg, exp);
         check({tag, "_hold_rdy"}, 35'(cachereq_rdy), 35'd0);
      end
      check({tag, "_msg"}, cacheresp_msg, exp);
      got = cacheresp_msg;
      cacheresp_rdy = 1'b1;
      @(negedge clk);
      cacheresp_rdy = 1'b0;
      check({tag, "_idle_rdy"}, 35'(cachereq_rdy), 35'd1);
      check({tag, "_idle_val"}, 35'(cacheresp_val), 35'd0);
   endtask

   initial begin
      logic [34:0] r;
      logic [34:0] expq[$];
      int          acc_cyc[$];
      int          cyc;
      int          acc;
      int          got_n;
      bit          t;
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  l;

      reset         = 1'b1;
      cachereq_val  = 1'b0;
      cachereq_msg  = 67'd0;
      cacheresp_rdy = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_req_rdy", 35'(cachereq_rdy), 35'd1);
      check("reset_resp_val", 35'(cacheresp_val), 35'd0);
      check("reset_resp_msg", cacheresp_msg, 35'd0);
      reset = 1'b0;
      @(negedge clk);

      // basic word write/read
      txn("t1_wr", 1'b1, 32'h0000_0100, 2'd0, 32'hDEAD_BEEF, 0, r);
      check("t1_wr_const", r, {1'b1, 2'd0, 32'd0});
      txn("t1_rd", 1'b0, 32'h0000_0100, 2'd0, 32'd0, 0, r);
      check("t1_rd_const", r, {1'b0, 2'd0, 32'hDEAD_BEEF});

      // byte write and sub-word reads
      txn("t2_wrb", 1'b1, 32'h0000_0103, 2'd1, 32'h1234_56AA, 0, r);
      txn("t2_rdw", 1'b0, 32'h0000_0100, 2'd0, 32'd0, 0, r);
      check("t2_rdw_const", r, {1'b0, 2'd0, 32'hAAAD_BEEF});
      txn("t2_rdh", 1'b0, 32'h0000_0102, 2'd2, 32'd0, 0, r);
      check("t2_rdh_const", r, {1'b0, 2'd2, 32'h0000_AAAD});

      // back-pressure on the response
      txn("t3_hold", 1'b0, 32'h0000_0101, 2'd1, 32'd0, 5, r);
      check("t3_hold_const", r, {1'b0, 2'd1, 32'h0000_00BE});

      // address wrap
      txn("t5_alias", 1'b0, 32'h0001_0100, 2'd0, 32'd0, 0, r);
      check("t5_alias_const", r, {1'b0, 2'd0, 32'hAAAD_BEEF});

      // back-to-back with request valid held high and consumer always ready
      cyc = 0; acc = 0; got_n = 0;
      cacheresp_rdy = 1'b1;
      t = 1'b1; a = 32'h0000_0200; l = 2'd0; d = $urandom;
      cachereq_msg = {t, a, l, d};
      cachereq_val = 1'b1;
      while (got_n < 6 && cyc < 200) begin
         if (cacheresp_val) begin
            if (expq.size() > 0) check("t4_msg", cacheresp_msg, expq.pop_front());
            else check("t4_spurious", 35'(cacheresp_val), 35'd0);
            got_n++;
         end
         if (cachereq_rdy && cachereq_val) begin
            expq.push_back(model_txn(t, a, l, d));
            acc_cyc.push_back(cyc);
            acc++;
         end
         @(posedge clk);
         #1;
         if (acc == 6) cachereq_val = 1'b0;
         if (!t) begin
            t = 1'b1; a = 32'h0000_0200 + 32'(4 * (acc / 2)); d = $urandom;
         end else begin
            t = 1'b0; d = 32'd0;
         end
         cachereq_msg = {t, a, l, d};
         @(negedge clk);
         cyc++;
      end
      cacheresp_rdy = 1'b0;
      cachereq_val  = 1'b0;
      check("t4_resp_count", 35'(got_n), 35'd6);
      check("t4_accept_count", 35'(acc_cyc.size()), 35'd6);
      check("t4_queue_empty", 35'(expq.size()), 35'd0);
      for (int i = 1; i < acc_cyc.size(); i++)
         check("t4_interval", 35'(acc_cyc[i] - acc_cyc[i-1]), 35'(L + 1));

      // reset while waiting after a write
      r = model_txn(1'b1, 32'h0000_0300, 2'd0, 32'h1234_5678);
      cachereq_msg = {1'b1, 32'h0000_0300, 2'd0, 32'h1234_5678};
      cachereq_val = 1'b1;
      check("t6_accept", 35'(cachereq_rdy), 35'd1);
      @(negedge clk);
      cachereq_val = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < L + 3; i++) begin
         check("t6_no_resp", 35'(cacheresp_val), 35'd0);
         check("t6_rdy", 35'(cachereq_rdy), 35'd1);
         @(negedge clk);
      end
      txn("t6_rd", 1'b0, 32'h0000_0300, 2'd0, 32'd0, 0, r);
      check("t6_rd_const", r, {1'b0, 2'd0, 32'h1234_5678});

      // randomized traffic over a small set of initialised words
      for (int k = 0; k < 8; k++)
         txn("rnd_init", 1'b1, 32'h0000_0400 + 32'(4 * k), 2'd0, $urandom, 0, r);
      for (int j = 0; j < 40; j++) begin
         a = 32'h0000_0400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3))
             + (32'($urandom_range(0, 3)) << 16);
         l = 2'($urandom_range(0, 3));
         t = 1'($urandom_range(0, 1));
         d = $urandom;
         txn("rnd", t, a, l, d, int'($urandom_range(0, 2)), r);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
